// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the initial carry that turns a + ~b into a - b.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic CARRY_INIT = 1'b1;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor. The overflow signal exists only
// when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             overflow;

  modport master (output start, a, b, input diff, borrow, busy, done, overflow);
  modport slave  (input start, a, b, output diff, borrow, busy, done, overflow);
`else
  modport master (output start, a, b, input diff, borrow, busy, done);
  modport slave  (input start, a, b, output diff, borrow, busy, done);
`endif
endinterface

// File: rtl/serial_subtractor_fa_cell.sv
// One-bit combinational full adder, the single arithmetic cell of the serial loop.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Optional signed overflow output enabled by SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             borrow_q;
  logic             sum_bit;
  logic             carry_out;
  logic             last_bit;
  logic             accept;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             overflow_q;
`endif

  // Subtraction as a + ~b + 1: invert the subtrahend bit here, the +1 is the initial carry.
  serial_fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (~b_sr[0]),
    .cin  (carry),
    .sum  (sum_bit),
    .cout (carry_out)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = ((state == IDLE) || (state == DONE)) && bus.start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = bus.start ? SHIFT : IDLE;
      SHIFT:      state_nxt = last_bit ? DONE : SHIFT;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      diff_q     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      borrow_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sr  <= bus.a;
        b_sr  <= bus.b;
        carry <= CARRY_INIT;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
        carry  <= carry_out;
        cnt    <= cnt + CNT_W'(1);
        // On the MSB edge, carry still holds the carry into the MSB.
        if (last_bit) begin
          diff_q     <= {sum_bit, res_sr[WIDTH-1:1]};
          borrow_q   <= ~carry_out;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          overflow_q <= carry ^ carry_out;
`endif
        end
      end
    end
  end

  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH = 8); checks overflow too when
// SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, "_diff"}, 32'(bus.diff), 32'(v.diff));
    check({tag, "_borrow"}, 32'(bus.borrow), 32'(v.borrow));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(v.ovf));
`endif
  endtask

  vec_t vecs[8];

  initial begin
    int   n;
    logic saw_done;
    vec_t v;

    checks    = 0;
    failures  = 0;
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    #1;
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_borrow", 32'(bus.borrow), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check("rst_overflow", 32'(bus.overflow), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of independent operations
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(n);
      check($sformatf("v%0d_latency", i), 32'(n), 32'd8);
      check($sformatf("v%0d_busy_in_done", i), 32'(bus.busy), 32'd0);
      check_result($sformatf("v%0d", i), vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d_diff_hold", i), 32'(bus.diff), 32'(vecs[i].diff));
    end

    // Start during SHIFT is ignored
    start_op(8'hFF, 8'h01);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.a     = 8'h00;
    bus.b     = 8'h01;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    check("ign_latency", 32'(n), 32'd5);
    v = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    check_result("ign", v);
    @(posedge clk);
    #1;
    check("ign_no_restart", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of an operation
    start_op(8'h55, 8'h11);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_borrow", 32'(bus.borrow), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    check("abort_overflow", 32'(bus.overflow), 32'd0);
`endif
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | bus.done;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | bus.done;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    start_op(8'h10, 8'h01);
    wait_done(n);
    check("post_rst_latency", 32'(n), 32'd8);
    v = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    check_result("post_rst", v);

    // Back-to-back: restart in the DONE cycle
    @(posedge clk);
    start_op(8'h05, 8'h03);
    wait_done(n);
    check("b2b_first_latency", 32'(n), 32'd8);
    @(negedge clk);
    bus.a     = 8'h03;
    bus.b     = 8'h05;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_done_drop", 32'(bus.done), 32'd0);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_diff_held", 32'(bus.diff), 32'h02);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    check("b2b_gap", 32'(n + 1), 32'd9);
    v = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    check_result("b2b", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
